// File: rtl/axi_lite_arbiter_2to1.sv
// axi_lite_arbiter_2to1: two-master AXI4-Lite arbiter sharing one slave port, one transaction in flight
// Ports: i_aclk/i_areset (async active-high); i_m0_*/o_m0_* and i_m1_*/o_m1_* master-side AXI4-Lite;
// o_s_*/i_s_* slave-side AXI4-Lite toward the bridge; o_gnt granted master index; o_busy transaction owned.
// Build option: ARB_FIXED_PRIO_EN makes M0 win every contention instead of round-robin.
module axi_lite_arbiter_2to1 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    i_aclk,
    input  logic                    i_areset,
    input  logic [ADDR_WIDTH-1:0]   i_m0_awaddr,
    input  logic                    i_m0_awvalid,
    output logic                    o_m0_awready,
    input  logic [DATA_WIDTH-1:0]   i_m0_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_m0_wstrb,
    input  logic                    i_m0_wvalid,
    output logic                    o_m0_wready,
    output logic [1:0]              o_m0_bresp,
    output logic                    o_m0_bvalid,
    input  logic                    i_m0_bready,
    input  logic [ADDR_WIDTH-1:0]   i_m0_araddr,
    input  logic                    i_m0_arvalid,
    output logic                    o_m0_arready,
    output logic [DATA_WIDTH-1:0]   o_m0_rdata,
    output logic [1:0]              o_m0_rresp,
    output logic                    o_m0_rvalid,
    input  logic                    i_m0_rready,
    input  logic [ADDR_WIDTH-1:0]   i_m1_awaddr,
    input  logic                    i_m1_awvalid,
    output logic                    o_m1_awready,
    input  logic [DATA_WIDTH-1:0]   i_m1_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_m1_wstrb,
    input  logic                    i_m1_wvalid,
    output logic                    o_m1_wready,
    output logic [1:0]              o_m1_bresp,
    output logic                    o_m1_bvalid,
    input  logic                    i_m1_bready,
    input  logic [ADDR_WIDTH-1:0]   i_m1_araddr,
    input  logic                    i_m1_arvalid,
    output logic                    o_m1_arready,
    output logic [DATA_WIDTH-1:0]   o_m1_rdata,
    output logic [1:0]              o_m1_rresp,
    output logic                    o_m1_rvalid,
    input  logic                    i_m1_rready,
    output logic [ADDR_WIDTH-1:0]   o_s_awaddr,
    output logic                    o_s_awvalid,
    input  logic                    i_s_awready,
    output logic [DATA_WIDTH-1:0]   o_s_wdata,
    output logic [DATA_WIDTH/8-1:0] o_s_wstrb,
    output logic                    o_s_wvalid,
    input  logic                    i_s_wready,
    input  logic [1:0]              i_s_bresp,
    input  logic                    i_s_bvalid,
    output logic                    o_s_bready,
    output logic [ADDR_WIDTH-1:0]   o_s_araddr,
    output logic                    o_s_arvalid,
    input  logic                    i_s_arready,
    input  logic [DATA_WIDTH-1:0]   i_s_rdata,
    input  logic [1:0]              i_s_rresp,
    input  logic                    i_s_rvalid,
    output logic                    o_s_rready,
    output logic                    o_gnt,
    output logic                    o_busy
);
    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA} state_t;
    state_t r_state, w_state_nxt;
    logic r_gnt, r_last, r_aw_done, r_w_done;
    logic w_gnt_nxt, w_last_nxt, w_aw_done_nxt, w_w_done_nxt;
    logic w_awvalid, w_wvalid, w_arvalid, w_bready, w_rready;
    logic w_awready, w_wready, w_arready, w_bvalid, w_rvalid;
    logic w_own0, w_own1, w_req0, w_req1, w_pick, w_pick_aw;
    logic w_aw_hs, w_w_hs, w_ar_hs, w_b_hs, w_r_hs;

    assign w_awvalid = r_gnt ? i_m1_awvalid : i_m0_awvalid;
    assign w_wvalid  = r_gnt ? i_m1_wvalid  : i_m0_wvalid;
    assign w_arvalid = r_gnt ? i_m1_arvalid : i_m0_arvalid;
    assign w_bready  = r_gnt ? i_m1_bready  : i_m0_bready;
    assign w_rready  = r_gnt ? i_m1_rready  : i_m0_rready;

    assign o_s_awaddr = r_gnt ? i_m1_awaddr : i_m0_awaddr;
    assign o_s_wdata  = r_gnt ? i_m1_wdata  : i_m0_wdata;
    assign o_s_wstrb  = r_gnt ? i_m1_wstrb  : i_m0_wstrb;
    assign o_s_araddr = r_gnt ? i_m1_araddr : i_m0_araddr;

    // done flags stop a channel from being re-presented after its handshake
    assign o_s_awvalid = r_state == WADDR && w_awvalid && !r_aw_done;
    assign o_s_wvalid  = r_state == WADDR && w_wvalid && !r_w_done;
    assign o_s_arvalid = r_state == RADDR && w_arvalid;
    assign o_s_bready  = r_state == WRESP && w_bready;
    assign o_s_rready  = r_state == RDATA && w_rready;

    assign w_awready = r_state == WADDR && !r_aw_done && i_s_awready;
    assign w_wready  = r_state == WADDR && !r_w_done && i_s_wready;
    assign w_arready = r_state == RADDR && i_s_arready;
    assign w_bvalid  = r_state == WRESP && i_s_bvalid;
    assign w_rvalid  = r_state == RDATA && i_s_rvalid;

    assign w_own0 = r_state != IDLE && !r_gnt;
    assign w_own1 = r_state != IDLE && r_gnt;

    assign o_m0_awready = w_awready && w_own0;
    assign o_m0_wready  = w_wready && w_own0;
    assign o_m0_arready = w_arready && w_own0;
    assign o_m0_bvalid  = w_bvalid && w_own0;
    assign o_m0_rvalid  = w_rvalid && w_own0;
    assign o_m0_bresp   = w_own0 ? i_s_bresp : 2'b00;
    assign o_m0_rresp   = w_own0 ? i_s_rresp : 2'b00;
    assign o_m0_rdata   = w_own0 ? i_s_rdata : '0;
    assign o_m1_awready = w_awready && w_own1;
    assign o_m1_wready  = w_wready && w_own1;
    assign o_m1_arready = w_arready && w_own1;
    assign o_m1_bvalid  = w_bvalid && w_own1;
    assign o_m1_rvalid  = w_rvalid && w_own1;
    assign o_m1_bresp   = w_own1 ? i_s_bresp : 2'b00;
    assign o_m1_rresp   = w_own1 ? i_s_rresp : 2'b00;
    assign o_m1_rdata   = w_own1 ? i_s_rdata : '0;

    assign w_aw_hs = o_s_awvalid && i_s_awready;
    assign w_w_hs  = o_s_wvalid && i_s_wready;
    assign w_ar_hs = o_s_arvalid && i_s_arready;
    assign w_b_hs  = o_s_bready && i_s_bvalid;
    assign w_r_hs  = o_s_rready && i_s_rvalid;

    assign w_req0 = i_m0_awvalid || i_m0_arvalid;
    assign w_req1 = i_m1_awvalid || i_m1_arvalid;
`ifdef ARB_FIXED_PRIO_EN
    assign w_pick = !w_req0;
`else
    // on contention the master not granted last time wins
    assign w_pick = w_req1 && (!w_req0 || !r_last);
`endif
    // a master with both requests pending gets its write first
    assign w_pick_aw = w_pick ? i_m1_awvalid : i_m0_awvalid;

    assign o_gnt  = r_gnt;
    assign o_busy = r_state != IDLE;

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_last_nxt    = r_last;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;
        case (r_state)
            IDLE: if (w_req0 || w_req1) begin
                w_gnt_nxt   = w_pick;
                w_last_nxt  = w_pick;
                w_state_nxt = w_pick_aw ? WADDR : RADDR;
            end
            WADDR: begin
                w_aw_done_nxt = r_aw_done || w_aw_hs;
                w_w_done_nxt  = r_w_done || w_w_hs;
                w_state_nxt   = w_aw_done_nxt && w_w_done_nxt ? WRESP : WADDR;
            end
            WRESP: if (w_b_hs) begin
                w_state_nxt   = IDLE;
                w_aw_done_nxt = 1'b0;
                w_w_done_nxt  = 1'b0;
            end
            RADDR:   w_state_nxt = w_ar_hs ? RDATA : RADDR;
            RDATA:   w_state_nxt = w_r_hs ? IDLE : RDATA;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            r_state   <= IDLE;
            r_gnt     <= 1'b0;
            r_last    <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_last    <= w_last_nxt;
            r_aw_done <= w_aw_done_nxt;
            r_w_done  <= w_w_done_nxt;
        end
    end
endmodule

// File: tb/tb_axi_lite_arbiter_2to1.sv
// tb_axi_lite_arbiter_2to1: random two-master traffic against a transaction-level arbitration and memory model
module tb_axi_lite_arbiter_2to1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] m_awaddr[2], m_wdata[2], m_araddr[2], m_rdata[2];
    logic [3:0]  m_wstrb[2];
    logic        m_awvalid[2], m_wvalid[2], m_bready[2], m_arvalid[2], m_rready[2];
    logic        m_awready[2], m_wready[2], m_bvalid[2], m_arready[2], m_rvalid[2];
    logic [1:0]  m_bresp[2], m_rresp[2];
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [3:0]  s_wstrb;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [1:0]  s_bresp, s_rresp;
    logic        o_gnt, o_busy;

    axi_lite_arbiter_2to1 dut (
        .i_aclk(clk), .i_areset(rst),
        .i_m0_awaddr(m_awaddr[0]), .i_m0_awvalid(m_awvalid[0]), .o_m0_awready(m_awready[0]),
        .i_m0_wdata(m_wdata[0]), .i_m0_wstrb(m_wstrb[0]), .i_m0_wvalid(m_wvalid[0]), .o_m0_wready(m_wready[0]),
        .o_m0_bresp(m_bresp[0]), .o_m0_bvalid(m_bvalid[0]), .i_m0_bready(m_bready[0]),
        .i_m0_araddr(m_araddr[0]), .i_m0_arvalid(m_arvalid[0]), .o_m0_arready(m_arready[0]),
        .o_m0_rdata(m_rdata[0]), .o_m0_rresp(m_rresp[0]), .o_m0_rvalid(m_rvalid[0]), .i_m0_rready(m_rready[0]),
        .i_m1_awaddr(m_awaddr[1]), .i_m1_awvalid(m_awvalid[1]), .o_m1_awready(m_awready[1]),
        .i_m1_wdata(m_wdata[1]), .i_m1_wstrb(m_wstrb[1]), .i_m1_wvalid(m_wvalid[1]), .o_m1_wready(m_wready[1]),
        .o_m1_bresp(m_bresp[1]), .o_m1_bvalid(m_bvalid[1]), .i_m1_bready(m_bready[1]),
        .i_m1_araddr(m_araddr[1]), .i_m1_arvalid(m_arvalid[1]), .o_m1_arready(m_arready[1]),
        .o_m1_rdata(m_rdata[1]), .o_m1_rresp(m_rresp[1]), .o_m1_rvalid(m_rvalid[1]), .i_m1_rready(m_rready[1]),
        .o_s_awaddr(s_awaddr), .o_s_awvalid(s_awvalid), .i_s_awready(s_awready),
        .o_s_wdata(s_wdata), .o_s_wstrb(s_wstrb), .o_s_wvalid(s_wvalid), .i_s_wready(s_wready),
        .i_s_bresp(s_bresp), .i_s_bvalid(s_bvalid), .o_s_bready(s_bready),
        .o_s_araddr(s_araddr), .o_s_arvalid(s_arvalid), .i_s_arready(s_arready),
        .i_s_rdata(s_rdata), .i_s_rresp(s_rresp), .i_s_rvalid(s_rvalid), .o_s_rready(s_rready),
        .o_gnt(o_gnt), .o_busy(o_busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    bit          act[2], wr[2], aw_ok[2], w_ok[2], ar_ok[2];
    logic [31:0] tx_addr[2], tx_data[2];
    logic [3:0]  tx_strb[2];
    int          left[2], mode[2], p_req;
    bit          ref_busy, ref_wr;
    int          ref_own, last;
    logic [31:0] ref_mem[16], smem[16];
    bit          sl_aw, sl_w, sl_b, sl_ar;
    logic [31:0] sl_awaddr, sl_wdata, sl_araddr;
    logic [3:0]  sl_wstrb;
    int          b_dly, r_dly;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [4:0] mvec(input int i);
        return {m_awready[i], m_wready[i], m_arready[i], m_bvalid[i], m_rvalid[i]};
    endfunction

    function automatic logic [16:0] all_out();
        return {o_busy, o_gnt, s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready, mvec(0), mvec(1)};
    endfunction

    task automatic reset_models();
        for (int i = 0; i < 2; i++) begin
            act[i] = 0; aw_ok[i] = 0; w_ok[i] = 0; ar_ok[i] = 0; left[i] = 0;
            m_awvalid[i] = 0; m_wvalid[i] = 0; m_arvalid[i] = 0; m_bready[i] = 0; m_rready[i] = 0;
            m_awaddr[i] = '0; m_araddr[i] = '0; m_wdata[i] = '0; m_wstrb[i] = '0;
        end
        sl_aw = 0; sl_w = 0; sl_b = 0; sl_ar = 0;
        sl_awaddr = '0; sl_araddr = '0; sl_wdata = '0; sl_wstrb = '0;
        s_awready = 0; s_wready = 0; s_arready = 0; s_bvalid = 0; s_rvalid = 0;
        s_bresp = 2'b00; s_rresp = 2'b00; s_rdata = '0;
        ref_busy = 0; ref_wr = 0; ref_own = 0; last = 1;
    endtask

    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            m_bready[i] = ($urandom % 4) != 0;
            m_rready[i] = ($urandom % 4) != 0;
            if (!act[i] && left[i] > 0 && int'($urandom % 100) < p_req) begin
                act[i] = 1;
                left[i]--;
                wr[i] = mode[i] == 1 ? 1'b1 : mode[i] == 2 ? 1'b0 : ($urandom % 2) == 1;
                tx_addr[i] = {26'b0, 4'($urandom % 16), 2'b00};
                tx_data[i] = $urandom;
                tx_strb[i] = 4'($urandom_range(1, 15));
                aw_ok[i] = 0; w_ok[i] = 0; ar_ok[i] = 0;
                m_awaddr[i] = tx_addr[i];
                m_araddr[i] = tx_addr[i];
                m_wdata[i] = tx_data[i];
                m_wstrb[i] = tx_strb[i];
            end
            m_awvalid[i] = act[i] && wr[i] && !aw_ok[i];
            m_wvalid[i]  = act[i] && wr[i] && !w_ok[i];
            m_arvalid[i] = act[i] && !wr[i] && !ar_ok[i];
        end
        s_awready = $urandom % 2;
        s_wready  = $urandom % 2;
        s_arready = $urandom % 2;
        if (sl_b) begin
            if (b_dly == 0) s_bvalid = 1; else b_dly--;
        end else s_bvalid = 0;
        if (sl_ar) begin
            if (r_dly == 0) s_rvalid = 1; else r_dly--;
        end else s_rvalid = 0;
        s_bresp = sl_awaddr[3:2];
        s_rresp = sl_araddr[3:2];
        s_rdata = smem[sl_araddr[5:2]];
    endtask

    task automatic sample();
        bit fin, r0, r1;
        int w;
        check("no_aw_ar_overlap", 64'(s_awvalid & s_arvalid), 0);
        check("no_dup_aw", 64'(s_awvalid & sl_aw), 0);
        check("no_dup_w", 64'(s_wvalid & sl_w), 0);
        check("no_dup_ar", 64'(s_arvalid & sl_ar), 0);
        fin = 0;
        if (!ref_busy) begin
            check("idle_busy", 64'(o_busy), 0);
            check("idle_s_ctl", 64'({s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready}), 0);
            check("idle_m0_quiet", 64'(mvec(0)), 0);
            check("idle_m1_quiet", 64'(mvec(1)), 0);
        end else begin
            check("busy", 64'(o_busy), 1);
            check("gnt", 64'(o_gnt), 64'(ref_own));
            check("other_quiet", 64'(mvec(1 - ref_own)), 0);
            check("xtype", 64'(ref_wr ? s_arvalid : (s_awvalid | s_wvalid)), 0);
            if (s_awvalid) check("s_awaddr", 64'(s_awaddr), 64'(tx_addr[ref_own]));
            if (s_wvalid) check("s_wdata_strb", 64'({s_wstrb, s_wdata}), 64'({tx_strb[ref_own], tx_data[ref_own]}));
            if (s_arvalid) check("s_araddr", 64'(s_araddr), 64'(tx_addr[ref_own]));
            fin = ref_wr ? (m_bvalid[ref_own] && m_bready[ref_own]) : (m_rvalid[ref_own] && m_rready[ref_own]);
        end
        for (int i = 0; i < 2; i++) begin
            if (act[i] && wr[i] && m_bvalid[i] && m_bready[i]) begin
                check("bresp", 64'(m_bresp[i]), 64'(tx_addr[i][3:2]));
                ref_mem[tx_addr[i][5:2]] = merge(ref_mem[tx_addr[i][5:2]], tx_data[i], tx_strb[i]);
                act[i] = 0;
            end
            if (act[i] && !wr[i] && m_rvalid[i] && m_rready[i]) begin
                check("rdata_rresp", 64'({m_rresp[i], m_rdata[i]}), 64'({tx_addr[i][3:2], ref_mem[tx_addr[i][5:2]]}));
                act[i] = 0;
            end
            if (m_awvalid[i] && m_awready[i]) aw_ok[i] = 1;
            if (m_wvalid[i] && m_wready[i]) w_ok[i] = 1;
            if (m_arvalid[i] && m_arready[i]) ar_ok[i] = 1;
        end
        if (s_bvalid && s_bready) begin
            sl_aw = 0; sl_w = 0; sl_b = 0;
        end
        if (s_rvalid && s_rready) sl_ar = 0;
        if (s_awvalid && s_awready) begin
            sl_aw = 1; sl_awaddr = s_awaddr;
        end
        if (s_wvalid && s_wready) begin
            sl_w = 1; sl_wdata = s_wdata; sl_wstrb = s_wstrb;
        end
        if (s_arvalid && s_arready) begin
            sl_ar = 1; sl_araddr = s_araddr; r_dly = $urandom % 3;
        end
        if (sl_aw && sl_w && !sl_b) begin
            sl_b = 1;
            b_dly = $urandom % 3;
            smem[sl_awaddr[5:2]] = merge(smem[sl_awaddr[5:2]], sl_wdata, sl_wstrb);
        end
        if (!ref_busy) begin
            r0 = m_awvalid[0] || m_arvalid[0];
            r1 = m_awvalid[1] || m_arvalid[1];
            if (r0 || r1) begin
`ifdef ARB_FIXED_PRIO_EN
                w = r0 ? 0 : 1;
`else
                w = (r0 && r1) ? 1 - last : (r0 ? 0 : 1);
`endif
                ref_busy = 1;
                ref_own = w;
                ref_wr = m_awvalid[w];
                last = w;
            end
        end else if (fin) ref_busy = 0;
    endtask

    task automatic run_phase(input int n0, input int n1, input int p, input int md0, input int md1, input bit stop_rd);
        left[0] = n0; left[1] = n1; p_req = p; mode[0] = md0; mode[1] = md1;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            drive();
            @(negedge clk);
            sample();
            if (stop_rd && ref_busy && !ref_wr && sl_ar) return;
            if (left[0] == 0 && left[1] == 0 && !act[0] && !act[1] && !ref_busy) break;
        end
        check("phase_done", 64'({act[0], act[1], ref_busy, left[0] != 0, left[1] != 0}), 0);
    endtask

    initial begin
        for (int a = 0; a < 16; a++) begin
            ref_mem[a] = '0;
            smem[a] = '0;
        end
        reset_models();
        rst = 1;
        repeat (3) @(posedge clk);
        #1 check("reset_outputs", 64'(all_out()), 0);
        rst = 0;
        run_phase(1, 1, 100, 2, 2, 0);
        run_phase(8, 8, 100, 1, 2, 0);
        run_phase(30, 30, 60, 0, 0, 0);
        run_phase(1, 0, 100, 2, 0, 1);
        @(posedge clk); #2;
        check("pre_reset_busy", 64'(o_busy), 1);
        rst = 1;
        #1 check("async_reset_outputs", 64'(all_out()), 0);
        reset_models();
        @(posedge clk); #1;
        check("held_reset_outputs", 64'(all_out()), 0);
        rst = 0;
        run_phase(20, 20, 70, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/axi_lite_arbiter_2to1.md
# axi_lite_arbiter_2to1

Two-master AXI4-Lite arbiter that shares the single AXI4-Lite slave port of the APB bridge (APB_TOP) between two requesters. It serialises traffic so exactly one transaction, either read or write, is in flight at the bridge at any time. This matches the bridge's single-outstanding behaviour. Arbitration is round-robin by default; fixed priority is available at compile time.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width on all ports
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8

Ports (Mx = M0 and M1, identical sets; S = downstream to bridge):
- ACLK  in  1  single clock for all logic
- ARESET  in  1  asynchronous, active-high reset
- Mx_AWADDR/AWVALID in, Mx_AWREADY out  ADDR_WIDTH/1/1  master write address
- Mx_WDATA/WSTRB/WVALID in, Mx_WREADY out  DATA_WIDTH/DATA_WIDTH/8/1/1  master write data
- Mx_BRESP/BVALID out, Mx_BREADY in  2/1/1  master write response
- Mx_ARADDR/ARVALID in, Mx_ARREADY out  ADDR_WIDTH/1/1  master read address
- Mx_RDATA/RRESP/RVALID out, Mx_RREADY in  DATA_WIDTH/2/1/1  master read data
- S_AW*, S_W*, S_B*, S_AR*, S_R*  mirror directions  same widths  slave side toward APB_TOP
- GNT  out  1  index of the granted master (registered)
- BUSY  out  1  high while a transaction is owned (any state except IDLE)

## Operation
- FSM states: IDLE, WADDR, WRESP, RADDR, RDATA.
- Request definitions: write request = Mx_AWVALID; read request = Mx_ARVALID.
- IDLE arbitration:
  - If any request is present, register GNT and the transaction type, then move to WADDR or RADDR.
  - If the chosen master has both write and read pending, the write goes first.
- Round-robin:
  - A 1-bit pointer `last` holds the master granted most recently.
  - On contention, the master that is not `last` wins.
  - `last` updates at grant time.
- WADDR:
  - S_AWVALID = Mx_AWVALID & !aw_done; S_WVALID = Mx_WVALID & !w_done.
  - Mx_AWREADY and Mx_WREADY pass through S_AWREADY and S_WREADY, gated the same way.
  - aw_done and w_done set on their handshakes; AW and W may complete in either order or together.
  - Move to WRESP when both are done.
- WRESP: S_BVALID, S_BRESP pass to Mx; S_BREADY = Mx_BREADY. On the B handshake go to IDLE and clear the done flags.
- RADDR: AR forwarded as in WADDR; on the AR handshake go to RDATA.
- RDATA: R passes through; on the R handshake go to IDLE.
- The non-granted master sees READY=0 and BVALID/RVALID=0 at all times.
- S_* payload (addr/data/strb) is a combinational mux on the registered GNT.
- A master deasserting VALID before its handshake violates AXI and is unsupported.

## Timing
- Reset: state IDLE, GNT=0, BUSY=0, `last`=1 so M0 wins the first contention, done flags 0. All VALID/READY outputs are 0.
- Reset is asynchronous. Assertion mid-transaction forces IDLE immediately and drops all outputs. The slave must be reset concurrently.
- Latency:
  - Request sampled in IDLE at edge N; S_AWVALID or S_ARVALID is high after edge N; no payload register stage.
  - The handshake itself adds 0 cycles (combinational ready path).
  - Completion: IDLE is re-entered on the edge of the B or R handshake. A new grant is made the next cycle.
  - Minimum back-to-back spacing is therefore 1 idle cycle between transactions.
- Response backpressure (Mx_BREADY or Mx_RREADY low) holds WRESP or RDATA indefinitely. The other master waits.

## Configuration
- ARB_FIXED_PRIO_EN defined:
  - M0 always wins contention; `last` is unused.
  - M1 may starve while M0 keeps requesting.
- Not defined: round-robin as above. Two continuously requesting masters are granted alternately: M0, M1, M0, …

## Test plan
- Reset check: hold ARESET=1 → all VALID/READY outputs, GNT and BUSY read 0. Pulse ARESET during RDATA → IDLE immediately and outputs 0.
- Single write from M0 (AWADDR=0x0, WDATA=0x000000A5, WSTRB=0001), then read of 0x0 → S sees the same address/data/strobe one cycle after AWVALID. M0 receives BRESP=00, then RDATA=0x000000A5 with RRESP=00. M1 outputs stay 0 throughout.
- Both masters assert ARVALID in the same cycle after reset → M0 served first (GNT=0), M1 second (GNT=1). S_ARVALID is never high for both; no overlap.
- M0 writes and M1 reads continuously for 8 transactions → grants strictly alternate. With ARB_FIXED_PRIO_EN, all 8 go to M0 and M1 waits.
- M0 holds BREADY low for 10 cycles after S_BVALID → FSM stays in WRESP with BUSY=1. A pending M1 request is not granted until the cycle after the B handshake.
- Slave accepts W two cycles before AW → no duplicate S_WVALID after w_done. Transition to WRESP happens only after the AW handshake.
